led_bank_scheduler: RTL and testbench

//  Shares the 4-bit board LED bank (prled) between NREQ requesters via round-robin with a timed hold.

---
 rtl/led_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/led_bank_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_led_bank_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank scheduler.
// Optional PWM dimming is enabled with `define LED_PWM_EN.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        HOLD
    } sched_state_t;

    localparam int LED_W = 4;

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr.
// The pointer register is owned by the instantiating module.
module rr_arbiter
    import led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = cw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [PW:0] j;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, ptr} + (PW+1)'(i);
            if (j >= (PW+1)'(NREQ)) begin
                j = j - (PW+1)'(NREQ);
            end
            if (!valid && req[j[PW-1:0]]) begin
                valid           = 1'b1;
                win[j[PW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_bank_scheduler.sv
// Round-robin time-sliced sharing of the 4-bit LED bank with idle heartbeat.
// Define LED_PWM_EN to add duty-controlled PWM dimming (+1 cycle latency).
module led_bank_scheduler
    import led_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DIV        = 1_000_000,
    parameter int HOLD_TICKS = 100,
    parameter int HB_TICKS   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [LED_W*NREQ-1:0] pat,
    input  logic [3:0]            duty,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [LED_W-1:0]      prled
);

    localparam int PW = cw(NREQ);
    localparam int DW = cw(DIV);
    localparam int HW = cw(HOLD_TICKS);
    localparam int BW = cw(HB_TICKS);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic [DW-1:0]   presc_q;
    logic [HW-1:0]   hold_q;
    logic [BW-1:0]   hb_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   own_q;
    logic [NREQ-1:0] gnt_q;
    logic [LED_W-1:0] led_q;

    logic [NREQ-1:0] win;
    logic            arb_valid;
    logic [PW-1:0]   widx;
    logic [PW-1:0]   nxt_ptr;
    logic [LED_W-1:0] cur_pat;
    logic            own_req;
    logic            tick;
    logic            hold_last;
    logic            hb_last;
    logic            enter_clr;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (arb_valid)
    );

    always_comb begin
        widx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                widx = PW'(i);
            end
        end
    end

    assign nxt_ptr = (widx == PW'(NREQ-1)) ? '0 : widx + PW'(1);

    always_comb begin
        cur_pat = '0;
        own_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_q == PW'(i)) begin
                cur_pat = pat[i*LED_W +: LED_W];
                own_req = req[i];
            end
        end
    end

    assign tick      = (presc_q == DW'(DIV-1));
    assign hold_last = (hold_q == HW'(HOLD_TICKS-1));
    assign hb_last   = (hb_q == BW'(HB_TICKS-1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                state_d = arb_valid ? HOLD : IDLE;
            end
            HOLD: begin
                if (!own_req || (tick && hold_last)) begin
                    state_d = ARB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timebase restarts whenever a hold or heartbeat period begins.
    assign enter_clr = (state_d != state_q) &&
                       (state_d == HOLD || state_d == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            hold_q  <= '0;
            hb_q    <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            if (enter_clr || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + DW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (hb_last) begin
                            hb_q     <= '0;
                            led_q[0] <= ~led_q[0];
                        end else begin
                            hb_q <= hb_q + BW'(1);
                        end
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        own_q  <= widx;
                        ptr_q  <= nxt_ptr;
                        gnt_q  <= win;
                        hold_q <= '0;
                    end else begin
                        led_q <= '0;
                        hb_q  <= '0;
                    end
                end
                HOLD: begin
                    led_q <= cur_pat;
                    if (tick) begin
                        hold_q <= hold_q + HW'(1);
                    end
                    if (state_d != HOLD) begin
                        gnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);

`ifdef LED_PWM_EN
    logic [3:0]       pwm_q;
    logic [LED_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
            out_q <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            out_q <= led_q & {LED_W{pwm_q <= duty}};
        end
    end

    assign prled = out_q;
`else
    logic unused_duty;

    assign unused_duty = ^duty;
    assign prled       = led_q;
`endif

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Randomized scoreboard bench for led_bank_scheduler against a cycle-count model.
// Works with or without LED_PWM_EN defined.
module tb_led_bank_scheduler;

    localparam int NREQ       = 4;
    localparam int DIV        = 4;
    localparam int HOLD_TICKS = 3;
    localparam int HB_TICKS   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [4*NREQ-1:0] pat;
    logic [3:0]      duty;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [3:0]      prled;

    led_bank_scheduler #(
        .NREQ       (NREQ),
        .DIV        (DIV),
        .HOLD_TICKS (HOLD_TICKS),
        .HB_TICKS   (HB_TICKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat   (pat),
        .duty  (duty),
        .gnt   (gnt),
        .busy  (busy),
        .prled (prled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [3:0]      led;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;

    typedef enum {M_IDLE, M_ARB, M_HOLD} mmode_t;

    mmode_t          m_mode  = M_IDLE;
    int              m_ptr   = 0;
    int              m_owner = 0;
    int              m_left  = 0;
    int              m_idle  = 0;
    logic [NREQ-1:0] m_gnt   = '0;
    logic [3:0]      m_led   = '0;
    logic [3:0]      m_out   = '0;
    logic [3:0]      m_pwm   = '0;

    // Behaviour described as elapsed-cycle budgets rather than tick counters.
    task automatic model_step();
        logic [3:0] led_before;
        logic [3:0] pwm_before;
        bit         found;
        int         w;
        exp_t       e;
        led_before = m_led;
        pwm_before = m_pwm;
        if (rst) begin
            m_mode = M_IDLE;
            m_led  = '0;
            m_gnt  = '0;
            m_ptr  = 0;
            m_idle = 0;
            m_out  = '0;
            m_pwm  = '0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_idle++;
                    m_led = '0;
                    m_led[0] = ((m_idle / (HB_TICKS*DIV)) % 2) == 1;
                    if (req != '0) m_mode = M_ARB;
                end
                M_ARB: begin
                    found = 1'b0;
                    for (int k = 0; k < NREQ; k++) begin
                        w = (m_ptr + k) % NREQ;
                        if (!found && req[w]) begin
                            found   = 1'b1;
                            m_owner = w;
                        end
                    end
                    if (found) begin
                        m_ptr  = (m_owner + 1) % NREQ;
                        m_gnt  = '0;
                        m_gnt[m_owner] = 1'b1;
                        m_left = HOLD_TICKS * DIV;
                        m_mode = M_HOLD;
                    end else begin
                        m_mode = M_IDLE;
                        m_led  = '0;
                        m_idle = 0;
                    end
                end
                default: begin
                    m_led = pat[m_owner*4 +: 4];
                    m_left--;
                    if (!req[m_owner] || m_left == 0) begin
                        m_mode = M_ARB;
                        m_gnt  = '0;
                    end
                end
            endcase
            m_out = led_before & {4{pwm_before <= duty}};
            m_pwm = pwm_before + 4'd1;
        end
        e.gnt  = m_gnt;
        e.busy = (m_mode != M_IDLE);
`ifdef LED_PWM_EN
        e.led  = m_out;
`else
        e.led  = m_led;
`endif
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    function automatic void chk(string nm, int got, int exp_v);
        checks++;
        if (got != exp_v) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp_v);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (sbq.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = sbq.pop_front();
                chk("gnt",   int'(gnt),   int'(e.gnt));
                chk("busy",  int'(busy),  int'(e.busy));
                chk("prled", int'(prled), int'(e.led));
            end
        end
    end

    initial begin : driver
        logic [NREQ-1:0] r;
        int              len;
        rst  = 1'b1;
        req  = '0;
        pat  = '0;
        duty = 4'd0;
        repeat (3) step();
        rst = 1'b0;
        repeat (40) step();
        for (int s = 0; s < 150; s++) begin
            r    = NREQ'($urandom);
            len  = $urandom_range(1, 40);
            duty = 4'($urandom);
            if (s % 5 == 0) begin
                r   = '0;
                len = $urandom_range(10, 40);
            end
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    r[$urandom_range(0, NREQ-1)] ^= 1'b1;
                end
                req = r;
                pat = (4*NREQ)'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        rst  = 1'b0;
        done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
